if_prefetch_buffer: RTL

//  Instruction prefetch unit between instruction memory and the decode stage of riscv_processor_top.

---
 rtl/if_prefetch_buffer_if.sv | 47 ++++
 rtl/if_prefetch_buffer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer_if.sv
// Handshake bundle around the instruction prefetch buffer: fetch request and
// response channels toward instruction memory, the redirect input, and the
// valid/ready channel toward decode. The master side is the prefetch buffer.
interface if_prefetch_buffer_if #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Fetch request channel
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;

    // Fetch response channel (in request order, no back-pressure)
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;

    // Control-flow redirect
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // Decode channel
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, occupancy,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, occupancy,
        output id_ready
    );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer. Issues sequential fetches under a credit limit
// (queued + in-flight <= DEPTH), queues returned instructions with their PCs,
// and hands them to decode. A redirect empties the queue and marks every
// in-flight fetch as stale so its response is dropped when it arrives.
module if_prefetch_buffer #(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,  // asynchronous, active-low
    if_prefetch_buffer_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;        // valid queue entries
    logic [CNT_W-1:0]  out_q, out_d;        // accepted requests awaiting a response
    logic [CNT_W-1:0]  drop_q, drop_d;      // oldest in-flight responses to discard
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;  // PC of the oldest non-dropped in-flight request

    logic [SUM_W-1:0]  credit_used;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_keep;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_base;

    assign credit_used   = SUM_W'(occ_q) + SUM_W'(out_q);
    assign redirect_base = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

    // Request side: fetch_pc only moves on accept, so valid/addr hold while stalled.
    assign bus.imem_req_valid = reset && (credit_used < SUM_W'(DEPTH));
    assign bus.imem_req_addr  = reset ? fetch_pc_q : '0;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = bus.imem_rsp_valid && (out_q != '0);
    assign rsp_keep = rsp_take && (drop_q == '0);
    // A redirect discards whatever would have been written this cycle.
    assign push     = rsp_keep && !bus.redirect_valid;
    assign pop      = bus.id_valid && bus.id_ready;

    // Decode side reads straight from registered storage; no response bypass.
    assign bus.id_valid  = (occ_q != '0);
    assign bus.id_instr  = bus.id_valid ? mem_q[rd_ptr_q].instr : '0;
    assign bus.id_pc     = bus.id_valid ? mem_q[rd_ptr_q].pc    : '0;
    assign bus.occupancy = occ_q;

    // Next-state for counters, queue pointers and both PC trackers.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        out_d      = out_q;
        drop_d     = drop_q;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;

        case ({req_fire, rsp_take})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

        // Redirect overrides the above after this cycle's handshakes are counted:
        // everything still in flight, including a request accepted now, is stale.
        if (bus.redirect_valid) begin
            drop_d     = out_d;
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
        end
    end

    // Control and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC_ALIGNED;
            rsp_pc_q   <= RESET_PC_ALIGNED;
        end else begin
            // NOTE: non-blocking assignments so every register samples this cycle's values, independent of statement order.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
        end
    end

    // Queue storage written at the tail with the response and its tracked PC.
    // NOTE: storage has no reset; an entry is only visible once occ_q covers it, and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{instr: bus.imem_rsp_data, pc: rsp_pc_q};
        end
    end

    // Protocol and bookkeeping invariants.
    a_rsp_needs_req: assert property (@(posedge clk) disable iff (!reset)
        bus.imem_rsp_valid |-> (out_q != '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
        credit_used <= SUM_W'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        drop_q <= out_q);
endmodule
